// File: rtl/wvb_wr_ctrl_gen2.sv
// Waveform buffer write controller: merges retriggers into one event, writes the buffer and
// emits one header per event. Optional max-length truncation: WVB_WR_CTRL_MAX_LEN_EN.
module wvb_wr_ctrl_gen2 #(
    parameter int unsigned P_ADR_WIDTH  = 12,
    parameter int unsigned P_LTC_WIDTH  = 48,
    parameter int unsigned P_PRE_WIDTH  = 5,
    parameter int unsigned P_POST_WIDTH = 8,
    parameter int unsigned P_TEST_WIDTH = 12,
    parameter int unsigned P_LEN_WIDTH  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_LTC_WIDTH-1:0]  i_ltc,
    input  logic                    i_trig,
    input  logic [1:0]              i_trig_src,
    input  logic                    i_trig_mode,
    input  logic                    i_arm,
    input  logic [P_PRE_WIDTH-1:0]  i_pre_config,
    input  logic [P_POST_WIDTH-1:0] i_post_config,
    input  logic [P_TEST_WIDTH-1:0] i_test_config,
    input  logic [P_LEN_WIDTH-1:0]  i_max_len,
    input  logic [P_ADR_WIDTH-1:0]  i_rd_addr,
    output logic                    o_wvb_wren,
    output logic [P_ADR_WIDTH-1:0]  o_wvb_wr_addr,
    output logic                    o_armed,
    output logic                    o_overflow,
    output logic                    o_hdr_valid,
    output logic [P_LTC_WIDTH-1:0]  o_hdr_ltc,
    output logic [P_ADR_WIDTH-1:0]  o_hdr_start_addr,
    output logic [P_ADR_WIDTH-1:0]  o_hdr_stop_addr,
    output logic [P_LEN_WIDTH-1:0]  o_hdr_evt_len,
    output logic [1:0]              o_hdr_trig_src,
    output logic                    o_hdr_trunc,
    output logic                    o_hdr_ovfl
);

    localparam logic [1:0] TRIG_SRC_EXT = 2'd1;
    localparam logic [1:0] TRIG_SRC_SW  = 2'd2;

    localparam logic [P_ADR_WIDTH-1:0]  L_ADR_ONE  = P_ADR_WIDTH'(1);
    localparam logic [P_PRE_WIDTH-1:0]  L_PRE_ONE  = P_PRE_WIDTH'(1);
    localparam logic [P_POST_WIDTH-1:0] L_POST_ONE = P_POST_WIDTH'(1);
    localparam logic [P_TEST_WIDTH-1:0] L_TEST_TWO = P_TEST_WIDTH'(2);
    localparam logic [P_LEN_WIDTH-1:0]  L_LEN_ONE  = P_LEN_WIDTH'(1);

    typedef enum logic [2:0] {StIdle, StSot, StPost, StTest, StHalt} state_e;

    state_e                  r_state;
    logic [P_ADR_WIDTH-1:0]  r_wr_addr;
    logic [P_LEN_WIDTH-1:0]  r_cnt;
    logic [P_PRE_WIDTH-1:0]  r_hold;
    logic [P_POST_WIDTH-1:0] r_post_cnt;
    logic [P_PRE_WIDTH-1:0]  r_pre;
    logic [P_POST_WIDTH-1:0] r_post;
    logic [P_TEST_WIDTH-1:0] r_test;
    logic                    r_armed;
    logic                    r_overflow;
    logic [P_LTC_WIDTH-1:0]  r_hdr_ltc;
    logic [P_ADR_WIDTH-1:0]  r_hdr_start;
    logic [1:0]              r_hdr_src;

    logic [P_ADR_WIDTH-1:0]  w_free;
    logic                    w_free_ok;
    logic                    w_accept;
    logic                    w_active;
    logic                    w_want;
    logic                    w_wren;
    logic [P_LEN_WIDTH-1:0]  w_cnt_now;
    logic                    w_trunc_hit;
    logic                    w_final_norm;
    logic                    w_final_trunc;
    logic                    w_ovfl_hdr;
    logic                    w_hdr_valid;
    logic [P_PRE_WIDTH-1:0]  w_pre_eff;
    logic [P_POST_WIDTH-1:0] w_post_eff;
    logic [P_TEST_WIDTH-1:0] w_test_eff;

    assign w_free     = i_rd_addr - r_wr_addr - L_ADR_ONE;
    assign w_free_ok  = (w_free != '0);
    // rst gates accept so the write strobe is low for the whole reset window
    assign w_accept   = i_trig && (!i_trig_mode || r_armed) && !r_overflow && !rst;
    assign w_active   = (r_state == StSot) || (r_state == StPost) || (r_state == StTest);
    assign w_want     = w_active || ((r_state == StIdle) && w_accept);
    assign w_wren     = w_want && w_free_ok;
    assign w_cnt_now  = (r_state == StIdle) ? L_LEN_ONE : r_cnt + L_LEN_ONE;

    assign w_pre_eff  = (i_pre_config == '0) ? L_PRE_ONE : i_pre_config;
    assign w_post_eff = (i_post_config == '0) ? L_POST_ONE : i_post_config;
    assign w_test_eff = (i_test_config < L_TEST_TWO) ? L_TEST_TWO : i_test_config;

`ifdef WVB_WR_CTRL_MAX_LEN_EN
    logic [P_LEN_WIDTH-1:0] r_max_len;
    assign w_trunc_hit = w_active && (r_max_len > L_LEN_ONE) && (w_cnt_now == r_max_len);
`else
    logic w_unused_max_len;
    assign w_unused_max_len = ^i_max_len;
    assign w_trunc_hit      = 1'b0;
`endif

    assign w_final_trunc = w_wren && w_trunc_hit;
    assign w_final_norm  = w_wren && !w_trunc_hit &&
        (((r_state == StPost) && !i_trig && (r_post_cnt == r_post - L_POST_ONE)) ||
         ((r_state == StTest) && (w_cnt_now == P_LEN_WIDTH'(r_test))));
    assign w_ovfl_hdr    = w_active && !w_free_ok && (r_cnt != '0);
    assign w_hdr_valid   = w_ovfl_hdr || w_final_trunc || w_final_norm;

    assign o_wvb_wren       = w_wren;
    assign o_wvb_wr_addr    = r_wr_addr;
    assign o_armed          = r_armed;
    assign o_overflow       = r_overflow;
    assign o_hdr_valid      = w_hdr_valid;
    assign o_hdr_ltc        = r_hdr_ltc;
    assign o_hdr_start_addr = r_hdr_start;
    assign o_hdr_trig_src   = r_hdr_src;
    assign o_hdr_trunc      = w_final_trunc;
    assign o_hdr_ovfl       = w_ovfl_hdr;
    assign o_hdr_stop_addr  = !w_hdr_valid ? '0 :
                              (w_ovfl_hdr ? r_wr_addr - L_ADR_ONE : r_wr_addr);
    assign o_hdr_evt_len    = !w_hdr_valid ? '0 : (w_ovfl_hdr ? r_cnt : w_cnt_now);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_wr_addr   <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_post_cnt  <= '0;
            r_pre       <= '0;
            r_post      <= '0;
            r_test      <= '0;
            r_armed     <= 1'b0;
            r_overflow  <= 1'b0;
            r_hdr_ltc   <= '0;
            r_hdr_start <= '0;
            r_hdr_src   <= '0;
`ifdef WVB_WR_CTRL_MAX_LEN_EN
            r_max_len   <= '0;
`endif
        end else begin
            if (w_wren) begin
                r_wr_addr <= r_wr_addr + L_ADR_ONE;
                r_cnt     <= w_cnt_now;
            end

            if (i_arm) begin
                r_armed <= 1'b1;
            end else if (w_hdr_valid) begin
                r_armed <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (!w_free_ok) begin
                            r_overflow <= 1'b1;
                            r_state    <= StHalt;
                        end else begin
                            r_hdr_ltc   <= i_ltc;
                            r_hdr_start <= r_wr_addr;
                            r_hdr_src   <= i_trig_src;
                            r_pre       <= w_pre_eff;
                            r_post      <= w_post_eff;
                            r_test      <= w_test_eff;
                            r_hold      <= w_pre_eff;
`ifdef WVB_WR_CTRL_MAX_LEN_EN
                            r_max_len   <= i_max_len;
`endif
                            if (i_trig_src == TRIG_SRC_SW || i_trig_src == TRIG_SRC_EXT) begin
                                r_state <= StTest;
                            end else begin
                                r_state <= StSot;
                            end
                        end
                    end
                end
                StSot, StPost, StTest: begin
                    // Priority: overflow, then truncation, then normal end / retrigger
                    if (!w_free_ok) begin
                        r_overflow <= 1'b1;
                        r_state    <= StHalt;
                        r_cnt      <= '0;
                    end else if (w_final_trunc || w_final_norm) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (r_state == StSot) begin
                        if (i_trig) begin
                            r_hold <= r_pre;
                        end else if (r_hold == L_PRE_ONE) begin
                            r_state    <= StPost;
                            r_post_cnt <= '0;
                        end else begin
                            r_hold <= r_hold - L_PRE_ONE;
                        end
                    end else if (r_state == StPost) begin
                        if (i_trig) begin
                            r_state <= StSot;
                            r_hold  <= r_pre;
                        end else begin
                            r_post_cnt <= r_post_cnt + L_POST_ONE;
                        end
                    end
                end
                StHalt: r_state <= StHalt;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wvb_wr_ctrl_gen2.sv
// Directed self-checking bench for wvb_wr_ctrl_gen2: event framing, retrigger merge, forced
// events, overflow, armed mode, max-length option and asynchronous reset.
module tb_wvb_wr_ctrl_gen2;

    localparam logic [47:0] LTC_BASE = 48'h0000_1234_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] i_ltc;
    logic        i_trig;
    logic [1:0]  i_trig_src;
    logic        i_trig_mode;
    logic        i_arm;
    logic [4:0]  i_pre_config;
    logic [7:0]  i_post_config;
    logic [11:0] i_test_config;
    logic [11:0] i_max_len;
    logic [11:0] i_rd_addr;
    logic        o_wvb_wren;
    logic [11:0] o_wvb_wr_addr;
    logic        o_armed;
    logic        o_overflow;
    logic        o_hdr_valid;
    logic [47:0] o_hdr_ltc;
    logic [11:0] o_hdr_start_addr;
    logic [11:0] o_hdr_stop_addr;
    logic [11:0] o_hdr_evt_len;
    logic [1:0]  o_hdr_trig_src;
    logic        o_hdr_trunc;
    logic        o_hdr_ovfl;

    wvb_wr_ctrl_gen2 dut (
        .clk              (clk),
        .rst              (rst),
        .i_ltc            (i_ltc),
        .i_trig           (i_trig),
        .i_trig_src       (i_trig_src),
        .i_trig_mode      (i_trig_mode),
        .i_arm            (i_arm),
        .i_pre_config     (i_pre_config),
        .i_post_config    (i_post_config),
        .i_test_config    (i_test_config),
        .i_max_len        (i_max_len),
        .i_rd_addr        (i_rd_addr),
        .o_wvb_wren       (o_wvb_wren),
        .o_wvb_wr_addr    (o_wvb_wr_addr),
        .o_armed          (o_armed),
        .o_overflow       (o_overflow),
        .o_hdr_valid      (o_hdr_valid),
        .o_hdr_ltc        (o_hdr_ltc),
        .o_hdr_start_addr (o_hdr_start_addr),
        .o_hdr_stop_addr  (o_hdr_stop_addr),
        .o_hdr_evt_len    (o_hdr_evt_len),
        .o_hdr_trig_src   (o_hdr_trig_src),
        .o_hdr_trunc      (o_hdr_trunc),
        .o_hdr_ovfl       (o_hdr_ovfl)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0;
    int n_wr, n_hdr, first_cyc, hdr_cyc;
    logic [11:0] first_addr, last_addr;
    logic [47:0] cap_ltc;
    logic [11:0] cap_start, cap_stop, cap_len;
    logic [1:0]  cap_src;
    logic        cap_trunc, cap_ovfl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        n_wr = 0; n_hdr = 0; first_cyc = -1; hdr_cyc = -1;
        first_addr = 'x; last_addr = 'x;
    endtask

    // Sample at negedge, then advance to 2 time units after the next rising edge
    task automatic step();
        @(negedge clk);
        if (o_wvb_wren) begin
            if (n_wr == 0) begin
                first_addr = o_wvb_wr_addr;
                first_cyc  = cyc;
            end
            last_addr = o_wvb_wr_addr;
            n_wr++;
        end
        if (o_hdr_valid) begin
            n_hdr++;
            hdr_cyc   = cyc;
            cap_ltc   = o_hdr_ltc;
            cap_start = o_hdr_start_addr;
            cap_stop  = o_hdr_stop_addr;
            cap_len   = o_hdr_evt_len;
            cap_src   = o_hdr_trig_src;
            cap_trunc = o_hdr_trunc;
            cap_ovfl  = o_hdr_ovfl;
        end
        @(posedge clk);
        #2;
        cyc++;
        i_ltc = LTC_BASE + 48'(cyc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fire();
        t0 = cyc;
        i_trig = 1'b1;
        step();
        i_trig = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_ltc = LTC_BASE; i_trig = 1'b0; i_trig_src = 2'd0; i_trig_mode = 1'b0;
        i_arm = 1'b0; i_pre_config = 5'd3; i_post_config = 8'd4; i_test_config = 12'd10;
        i_max_len = 12'd0; i_rd_addr = 12'd0;
        clear();
        run(2);
        i_trig = 1'b1;
        #1;
        chk("reset_wren", 64'(o_wvb_wren), 64'd0);
        chk("reset_outs", {o_wvb_wr_addr, o_armed, o_overflow, o_hdr_valid, o_hdr_evt_len},
            64'd0);
        i_trig = 1'b0;
        rst = 1'b0;
        run(2);

        // Isolated event: 1 + 3 + 4 writes
        clear(); fire(); run(12);
        chk("iso_nwr", 64'(n_wr), 64'd8);
        chk("iso_nhdr", 64'(n_hdr), 64'd1);
        chk("iso_first_cyc", 64'(first_cyc), 64'(t0));
        chk("iso_hdr_cyc", 64'(hdr_cyc), 64'(t0 + 7));
        chk("iso_addrs", {first_addr, last_addr}, {12'd0, 12'd7});
        chk("iso_hdr", {cap_start, cap_stop, cap_len}, {12'd0, 12'd7, 12'd8});
        chk("iso_ltc", cap_ltc, LTC_BASE + 48'(t0));
        chk("iso_flags", {cap_src, cap_trunc, cap_ovfl}, 64'd0);

        // Retrigger on 2nd POST cycle; config changes mid-event ignored
        clear(); fire();
        i_pre_config = 5'd7; i_post_config = 8'd20;
        run(4); fire(); run(15);
        i_pre_config = 5'd3; i_post_config = 8'd4;
        chk("retrig_nwr", 64'(n_wr), 64'd13);
        chk("retrig_nhdr", 64'(n_hdr), 64'd1);
        chk("retrig_hdr_cyc", 64'(hdr_cyc), 64'(first_cyc + 12));
        chk("retrig_hdr", {cap_start, cap_stop, cap_len}, {12'd8, 12'd20, 12'd13});

        // Forced SW event, retriggers ignored
        i_trig_src = 2'd2;
        clear(); fire(); int_first: begin end
        run(2); i_trig = 1'b1; step(); i_trig = 1'b0;
        run(2); i_trig = 1'b1; step(); i_trig = 1'b0;
        run(10);
        chk("test_nwr", 64'(n_wr), 64'd10);
        chk("test_nhdr", 64'(n_hdr), 64'd1);
        chk("test_hdr_cyc", 64'(hdr_cyc), 64'(first_cyc + 9));
        chk("test_hdr", {cap_start, cap_stop, cap_len, cap_src}, {12'd21, 12'd30, 12'd10, 2'd2});

        // Minimum configs: pre/post 0 -> 1, test 1 -> 2
        i_trig_src = 2'd0; i_pre_config = 5'd0; i_post_config = 8'd0;
        clear(); fire(); run(6);
        chk("min_pp", {n_wr[11:0], cap_start, cap_stop, cap_len},
            {12'd3, 12'd31, 12'd33, 12'd3});
        i_trig_src = 2'd1; i_test_config = 12'd1;
        clear(); fire(); run(6);
        chk("min_test", {n_wr[11:0], cap_start, cap_stop, cap_len, cap_src},
            {12'd2, 12'd34, 12'd35, 12'd2, 2'd1});

        // max_len 5
        i_trig_src = 2'd0; i_pre_config = 5'd3; i_post_config = 8'd4; i_max_len = 12'd5;
        clear(); fire(); run(12);
`ifdef WVB_WR_CTRL_MAX_LEN_EN
        chk("maxlen_nwr", 64'(n_wr), 64'd5);
        chk("maxlen_hdr", {cap_stop, cap_len, cap_trunc, cap_ovfl}, {12'd40, 12'd5, 2'b10});
`else
        chk("maxlen_off_nwr", 64'(n_wr), 64'd8);
        chk("maxlen_off_hdr", {cap_stop, cap_len, cap_trunc, cap_ovfl}, {12'd43, 12'd8, 2'b00});
`endif
        i_max_len = 12'd0;

        // Async reset mid-event
        clear(); fire(); run(2);
        rst = 1'b1; i_trig = 1'b1;
        #1;
        chk("arst_wren", 64'(o_wvb_wren), 64'd0);
        chk("arst_outs", {o_wvb_wr_addr, o_hdr_valid, o_hdr_start_addr, o_hdr_evt_len,
                          o_hdr_trig_src, o_armed, o_overflow}, 64'd0);
        chk("arst_ltc", o_hdr_ltc, 48'd0);
        i_trig = 1'b0;
        clear(); run(3);
        rst = 1'b0;
        run(6);
        chk("arst_no_hdr", {32'(n_hdr), 32'(n_wr)}, 64'd0);

        // Overflow: rd_addr 5 leaves room for 4 writes
        i_rd_addr = 12'd5;
        clear(); fire(); run(8);
        chk("ovf_nwr", 64'(n_wr), 64'd4);
        chk("ovf_nhdr", 64'(n_hdr), 64'd1);
        chk("ovf_hdr_cyc", 64'(hdr_cyc), 64'(first_cyc + 4));
        chk("ovf_hdr", {cap_stop, cap_len, cap_ovfl, cap_trunc}, {12'd3, 12'd4, 2'b10});
        chk("ovf_sticky", 64'(o_overflow), 64'd1);
        i_rd_addr = 12'd100;
        clear(); fire(); run(10); fire(); run(10);
        chk("halt_no_wr", {32'(n_wr), 32'(n_hdr)}, 64'd0);
        rst = 1'b1; step(); rst = 1'b0; i_rd_addr = 12'd0;
        chk("ovf_clr", {o_overflow, o_wvb_wr_addr}, 64'd0);

        // Armed one-shot mode
        i_trig_mode = 1'b1;
        clear(); fire(); run(4);
        chk("unarmed_nwr", 64'(n_wr), 64'd0);
        i_arm = 1'b1; step(); i_arm = 1'b0;
        chk("armed_set", 64'(o_armed), 64'd1);
        clear(); fire(); run(10); fire(); run(10);
        chk("oneshot_nwr", 64'(n_wr), 64'd8);
        chk("oneshot_nhdr", 64'(n_hdr), 64'd1);
        chk("oneshot_start", 64'(cap_start), 64'd0);
        chk("armed_drop", 64'(o_armed), 64'd0);
        // arm coincident with hdr_valid keeps armed
        i_arm = 1'b1; step(); i_arm = 1'b0;
        clear(); fire(); run(6);
        i_arm = 1'b1; step(); i_arm = 1'b0;
        chk("arm_coinc_hdr_cyc", 64'(hdr_cyc), 64'(t0 + 7));
        chk("arm_coinc_armed", 64'(o_armed), 64'd1);
        clear(); fire(); run(10);
        chk("rearm_event", {n_wr[11:0], cap_start, cap_stop}, {12'd8, 12'd16, 12'd23});
        chk("rearm_drop", 64'(o_armed), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wvb_wr_ctrl_gen2.md
Name: wvb_wr_ctrl_gen2

Overview:
Second-generation waveform buffer write controller for the mDOM ADC channel.
- Generates write enable and address into the waveform buffer.
- Merges retriggers into one event and emits one header word set per event.
- New over the first generation: free-space-based overflow detection from the reader's address, optional maximum-event-length truncation, and evt_len carried in the header.
- Sits between the per-channel trigger logic and the wvb/header FIFOs.

Parameters:
P_ADR_WIDTH, 12, waveform buffer address width
P_LTC_WIDTH, 48, local time counter width
P_PRE_WIDTH, 5, pre-trigger length config width
P_POST_WIDTH, 8, post-trigger length config width
P_TEST_WIDTH, 12, test/forced event length config width
P_LEN_WIDTH, 12, event length / max-length width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ltc  in  P_LTC_WIDTH  local time counter
trig  in  1  trigger pulse, one cycle per sample over threshold
trig_src  in  2  trigger source; TRIG_SRC_SW/TRIG_SRC_EXT select forced events
trig_mode  in  1  0 = continuous, 1 = armed one-shot
arm  in  1  arm pulse (mode 1)
pre_config  in  P_PRE_WIDTH  pre-trigger samples
post_config  in  P_POST_WIDTH  post-trigger samples
test_config  in  P_TEST_WIDTH  forced event length
max_len  in  P_LEN_WIDTH  maximum event length (optional feature)
rd_addr  in  P_ADR_WIDTH  reader's next read address
wvb_wren  out  1  buffer write enable
wvb_wr_addr  out  P_ADR_WIDTH  buffer write address
armed  out  1  armed flag
overflow  out  1  sticky overflow
hdr_valid  out  1  header write strobe, one cycle per event
hdr_ltc  out  P_LTC_WIDTH  LTC at first write
hdr_start_addr  out  P_ADR_WIDTH  address of first write
hdr_stop_addr  out  P_ADR_WIDTH  address of last write
hdr_evt_len  out  P_LEN_WIDTH  number of writes in event
hdr_trig_src  out  2  trig_src at first write
hdr_trunc  out  1  event ended by max_len
hdr_ovfl  out  1  event ended by overflow

Behaviour:
- Reset (async, any cycle, including mid-event): all outputs 0, wvb_wr_addr 0, FSM to IDLE, all counters 0. No header is emitted for an aborted event.
- Effective configs, captured on the start cycle:
  - pre = max(pre_config, 1)
  - post = max(post_config, 1)
  - test = max(test_config, 2)
- free = rd_addr - wvb_wr_addr - 1, mod 2^P_ADR_WIDTH. A write is blocked when free == 0.
- accept = trig && (trig_mode == 0 || armed) && !overflow.
- wvb_wren is combinational: asserted when (state != IDLE && state != HALT, or accept in IDLE) and free != 0.
- Each write increments wvb_wr_addr (wraps) and the length count.
- States:
  - IDLE: on accept, write count 1, latch ltc, trig_src and start address.
    - trig_src SW or EXT -> TEST.
    - Otherwise -> SOT with hold = pre.
  - SOT: write every cycle; hold decrements.
    - trig reloads hold = pre.
    - Last hold cycle without trig -> POST, cnt = 0.
  - POST: write every cycle.
    - trig -> SOT with hold = pre.
    - Write with cnt == post-1 and no trig is the final write -> IDLE.
  - TEST: trig ignored; the write bringing the count to test is final -> IDLE.
  - HALT: no writes; left only by rst.
- Isolated event length = 1 + pre + post.
  - Example: pre 3, post 4 -> 8 writes.
- Header:
  - hdr_valid asserts combinationally on the final-write cycle.
  - hdr_stop_addr = address of that write; hdr_evt_len = count including it.
  - All hdr_* fields are stable that cycle.
- Overflow (priority 1):
  - A write blocked by free == 0 in an active state, or on an accepted trigger in IDLE, sets overflow (sticky) -> HALT.
  - If count > 0: hdr_valid pulses that cycle with hdr_ovfl = 1, hdr_stop_addr = wvb_wr_addr - 1, hdr_evt_len = count.
  - If count == 0: no header.
- Truncation (priority 2, optional feature): final write forced when count reaches max_len; hdr_trunc = 1. Takes precedence over a coincident trig.
- Normal end: priority 3.
- armed:
  - Set by arm, cleared by hdr_valid.
  - arm coincident with hdr_valid leaves armed = 1.
  - Mode 0 ignores armed.
- Config inputs changing mid-event have no effect.

Optional Feature:
WVB_WR_CTRL_MAX_LEN_EN
- Defined: max_len truncation active. A max_len value < 2 means unlimited.
- Undefined: max_len ignored, hdr_trunc tied 0, truncation logic absent; events are bounded only by overflow.

Test Plan:
- pre 3, post 4, single trig at t0, mode 0, empty buffer -> writes t0..t0+7; hdr_valid at t0+7 with evt_len 8, start 0, stop 7.
- Same config, second trig at the 2nd POST cycle -> one event; POST restarts after 3 SOT cycles; evt_len 1+3+2+3+4 = 13; single hdr_valid.
- trig_src SW, test 10, trig during event -> exactly 10 writes; hdr_valid on 10th; retrigger ignored.
- rd_addr = 5, wvb_wr_addr = 0, pre 3, post 4 -> 4 writes (addr 0-3); overflow set; hdr_ovfl 1, evt_len 4, stop 3; FSM in HALT; further trigs produce no writes until rst.
- Mode 1: trig without arm -> no write; arm then two events -> only the first recorded; armed drops with its hdr_valid.
- With WVB_WR_CTRL_MAX_LEN_EN, max_len 5, pre 3, post 4 -> 5 writes, hdr_trunc 1, evt_len 5; async rst mid-event -> all outputs 0 immediately, no header.
